// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: shared writeback widths, register-file constants, source encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_ctrl_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_AW;

  // x0 is hardwired zero; writes to it are dropped and never tracked
  localparam logic [REG_AW-1:0] ZERO_REG  = '0;
  localparam logic              WE_ACTIVE = 1'b1;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    reg_addr_t addr;
    data_t     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_SKID,
    SRC_LS,
    SRC_EX
  } wb_src_t;

  function automatic logic is_tracked(reg_addr_t a);
    return a != ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// wb_ctrl_if: EX/long-latency result inputs, issue tracking, register-file write port.
// Latency: n/a (wires only).
// Backpressure: exStallOut holds EX/ID; lsReadyOut is the long-latency ready.
interface wb_ctrl_if;
  import wb_ctrl_pkg::*;

  logic                exValidIn;
  reg_addr_t           exAddrIn;
  data_t               exDataIn;
  logic                exStallOut;
  logic                lsValidIn;
  reg_addr_t           lsAddrIn;
  data_t               lsDataIn;
  logic                lsReadyOut;
  logic                issueValidIn;
  reg_addr_t           issueAddrIn;
  logic                wFlagOut;
  reg_addr_t           wAddrOut;
  data_t               wDataOut;
  logic [NUM_REGS-1:0] busyOut;

  modport master (
    output exValidIn, exAddrIn, exDataIn,
    output lsValidIn, lsAddrIn, lsDataIn,
    output issueValidIn, issueAddrIn,
    input  exStallOut, lsReadyOut, wFlagOut, wAddrOut, wDataOut, busyOut
  );

  modport slave (
    input  exValidIn, exAddrIn, exDataIn,
    input  lsValidIn, lsAddrIn, lsDataIn,
    input  issueValidIn, issueAddrIn,
    output exStallOut, lsReadyOut, wFlagOut, wAddrOut, wDataOut, busyOut
  );

endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: busy bit per register for pending long-latency writes (built with WB_SCOREBOARD_EN).
// Latency: set/clear visible on busy one cycle after the edge; set wins over clear.
// Backpressure: none. Ports: clk, rst, setEn/setAddr, clrEn/clrAddr, busy vector.
module wb_scoreboard
  import wb_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                setEn,
  input  reg_addr_t           setAddr,
  input  logic                clrEn,
  input  reg_addr_t           clrAddr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;

  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (setEn && is_tracked(setAddr)) setMask[setAddr] = 1'b1;
    if (clrEn && is_tracked(clrAddr)) clrMask[clrAddr] = 1'b1;
  end

  // OR-ing the set mask after the clear makes a same-address set win
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clrMask) | setMask;
  end

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: arbitrates EX and long-latency results onto the register-file write port.
// Latency: source selected in cycle N is written (wFlagOut/wAddrOut/wDataOut) in cycle N+1.
// Backpressure: lsReadyOut low while EX wins or skid full; exStallOut one cycle per skid capture.
// Ports: clk, rst (async active-high), wb (wb_ctrl_if.slave). Optional WB_SCOREBOARD_EN adds busyOut tracking.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  wb_ctrl_if.slave   wb
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic             skidFull;
  wb_req_t          skidEntry;
  logic [CNT_W-1:0] starveCnt;
  logic             wFlag;
  wb_req_t          wReq;

  logic    starved;
  logic    lsReady;
  logic    lsAccept;
  logic    skidCapture;
  wb_src_t src;
  wb_req_t sel;

  assign starved  = wb.lsValidIn && (starveCnt == CNT_MAX);
  assign lsReady  = !rst && !skidFull && (!wb.exValidIn || starved);
  assign lsAccept = wb.lsValidIn && lsReady;

  // A starved long-latency result displaces a concurrent EX result into the skid
  assign skidCapture = starved && !skidFull && wb.exValidIn;

  always_comb begin
    src = SRC_NONE;
    if (skidFull)            src = SRC_SKID;
    else if (starved)        src = SRC_LS;
    else if (wb.exValidIn)   src = SRC_EX;
    else if (wb.lsValidIn)   src = SRC_LS;
  end

  always_comb begin
    sel = skidEntry;
    case (src)
      SRC_SKID: sel = skidEntry;
      SRC_LS:   sel = '{addr: wb.lsAddrIn, data: wb.lsDataIn};
      SRC_EX:   sel = '{addr: wb.exAddrIn, data: wb.exDataIn};
      default:  sel = skidEntry;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skidFull  <= 1'b0;
      skidEntry <= '0;
      starveCnt <= '0;
      wFlag     <= ~WE_ACTIVE;
      wReq      <= '0;
    end else begin
      // Skid drains in the cycle it is full, and cannot be refilled that cycle
      skidFull <= skidCapture;
      if (skidCapture) skidEntry <= '{addr: wb.exAddrIn, data: wb.exDataIn};

      if (!wb.lsValidIn || lsAccept) starveCnt <= '0;
      else if (starveCnt != CNT_MAX) starveCnt <= starveCnt + 1'b1;

      // x0 still completes its handshake but never raises the write enable
      wFlag <= ((src != SRC_NONE) && (sel.addr != ZERO_REG)) ? WE_ACTIVE : ~WE_ACTIVE;
      if (src != SRC_NONE) wReq <= sel;
    end
  end

  assign wb.lsReadyOut = lsReady;
  assign wb.exStallOut = skidFull;
  assign wb.wFlagOut   = wFlag;
  assign wb.wAddrOut   = wReq.addr;
  assign wb.wDataOut   = wReq.data;

`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;

  wb_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .setEn   (wb.issueValidIn),
    .setAddr (wb.issueAddrIn),
    .clrEn   (lsAccept),
    .clrAddr (wb.lsAddrIn),
    .busy    (busy)
  );

  assign wb.busyOut = busy;
`else
  logic unused_issue;
  assign unused_issue = ^{wb.issueValidIn, wb.issueAddrIn};
  assign wb.busyOut   = '0;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed + random stimulus for wb_ctrl with a queue-based reference model.
// Latency: expected writes queued when issued, popped by a monitor one cycle later.
// Backpressure: long-latency results held until the DUT accepts them.
module tb_wb_ctrl;
  import wb_ctrl_pkg::*;

  localparam int LIMIT = STARVE_LIMIT_DEFAULT;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_ctrl_if wb ();

  wb_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  int  checks = 0;
  int  passes = 0;

  // Reference state: at most one displaced EX result waiting, writes due next cycle,
  // how long the current long-latency result has been waiting, and pending destinations.
  wr_t skidQ[$];
  wr_t expQ[$];
  int  lsWait = 0;
  bit  mbusy[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_busy();
    logic [31:0] v = '0;
`ifdef WB_SCOREBOARD_EN
    for (int i = 1; i < 32; i++) v[i] = mbusy[i];
`endif
    return v;
  endfunction

  task automatic model_reset();
    skidQ.delete();
    expQ.delete();
    lsWait = 0;
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
  endtask

  task automatic drive_idle();
    wb.exValidIn = 1'b0; wb.exAddrIn = '0; wb.exDataIn = '0;
    wb.lsValidIn = 1'b0; wb.lsAddrIn = '0; wb.lsDataIn = '0;
    wb.issueValidIn = 1'b0; wb.issueAddrIn = '0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld,
                      input bit iv, input logic [4:0] ia, output bit dutAcc);
    bit  skidBusy, starved, expReady, accept, have;
    wr_t w;
    wb.exValidIn = ev; wb.exAddrIn = ea; wb.exDataIn = ed;
    wb.lsValidIn = lv; wb.lsAddrIn = la; wb.lsDataIn = ld;
    wb.issueValidIn = iv; wb.issueAddrIn = ia;
    #1;
    skidBusy = skidQ.size() != 0;
    starved  = lv && (lsWait >= LIMIT);
    expReady = !skidBusy && (!ev || starved);
    accept   = lv && expReady;
    have     = 1'b0;
    w        = '0;
    if (skidBusy) begin
      w = skidQ.pop_front(); have = 1'b1;
    end else if (starved) begin
      w = '{la, ld}; have = 1'b1;
      if (ev) skidQ.push_back('{ea, ed});
    end else if (ev) begin
      w = '{ea, ed}; have = 1'b1;
    end else if (lv) begin
      w = '{la, ld}; have = 1'b1;
    end
    if (have && w.a != 5'd0) expQ.push_back(w);
    chk("lsReadyOut", 64'(wb.lsReadyOut), 64'(expReady));
    dutAcc = lv && wb.lsReadyOut;
    if (!lv || accept) lsWait = 0;
    else if (lsWait < LIMIT) lsWait++;
    if (accept && la != 5'd0) mbusy[la] = 1'b0;
    if (iv && ia != 5'd0) mbusy[ia] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("exStallOut", 64'(wb.exStallOut), 64'(skidQ.size() != 0));
    chk("busyOut", 64'(wb.busyOut), 64'(exp_busy()));
  endtask

  task automatic idle_step();
    bit a;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, a);
  endtask

  // Monitor: every cycle the write port must show exactly what the model queued.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("wFlagOut", 64'(wb.wFlagOut), 64'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        if (wb.wFlagOut) begin
          chk("wAddrOut", 64'(wb.wAddrOut), 64'(e.a));
          chk("wDataOut", 64'(wb.wDataOut), 64'(e.d));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d checks passed so far)", passes, checks);
    $fatal(1);
  end

  initial begin
    bit          acc, lsP, ev, iv;
    logic [4:0]  la, ia;
    logic [31:0] ld;
    int          n;

    drive_idle();
    model_reset();
    wb.lsValidIn = 1'b1;
    #2;
    chk("rst_wFlagOut", 64'(wb.wFlagOut), 64'd0);
    chk("rst_wAddrOut", 64'(wb.wAddrOut), 64'd0);
    chk("rst_wDataOut", 64'(wb.wDataOut), 64'd0);
    chk("rst_exStallOut", 64'(wb.exStallOut), 64'd0);
    chk("rst_busyOut", 64'(wb.busyOut), 64'd0);
    chk("rst_lsReadyOut", 64'(wb.lsReadyOut), 64'd0);
    @(negedge clk);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    idle_step();

    // EX-only write, then EX to x0
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, acc);
    step(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, acc);
    idle_step();

    // Collision: EX wins, long-latency accepted the next cycle
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, acc);
    chk("collide_first_acc", 64'(acc), 64'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, acc);
    chk("collide_second_acc", 64'(acc), 64'd1);
    idle_step();

    // Starvation: EX every cycle, long-latency held
    n = 0; acc = 1'b0;
    while (!acc && n < 12) begin
      n++;
      step(1'b1, 5'(10 + n), 32'(32'hE000 + n), 1'b1, 5'd20, 32'h5A5A5A5A, 1'b0, 5'd0, acc);
    end
    chk("starve_accept_cycle", 64'(n), 64'(LIMIT + 1));
    chk("starve_stall", 64'(wb.exStallOut), 64'd1);
    // EX input while stalled is ignored; the skid entry is written instead
    step(1'b1, 5'd31, 32'hBADBAD00, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, acc);
    chk("stall_one_cycle", 64'(wb.exStallOut), 64'd0);
    step(1'b1, 5'd17, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, acc);
    idle_step();

    // Scoreboard set, clear, simultaneous set+clear, x0 ignored
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, acc);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h700, 1'b0, 5'd0, acc);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h701, 1'b1, 5'd7, acc);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, acc);

    // Reset with skid full and x7 pending
    n = 0; acc = 1'b0;
    while (!acc && n < 12) begin
      n++;
      step(1'b1, 5'(2 + n), 32'(32'hC000 + n), 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, acc);
    end
    chk("pre_reset_stall", 64'(wb.exStallOut), 64'd1);
    #2;
    rst = 1'b1;
    drive_idle();
    #1;
    model_reset();
    chk("mid_rst_wFlagOut", 64'(wb.wFlagOut), 64'd0);
    chk("mid_rst_wAddrOut", 64'(wb.wAddrOut), 64'd0);
    chk("mid_rst_wDataOut", 64'(wb.wDataOut), 64'd0);
    chk("mid_rst_exStallOut", 64'(wb.exStallOut), 64'd0);
    chk("mid_rst_busyOut", 64'(wb.busyOut), 64'd0);
    chk("mid_rst_lsReadyOut", 64'(wb.lsReadyOut), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) idle_step();

    // Random traffic
    lsP = 1'b0; la = '0; ld = '0;
    for (int i = 0; i < 600; i++) begin
      if (!lsP && $urandom_range(0, 2) == 0) begin
        lsP = 1'b1;
        la  = 5'($urandom_range(0, 31));
        ld  = $urandom;
      end
      ev = ($urandom_range(0, 3) != 0);
      iv = ($urandom_range(0, 3) == 0);
      ia = 5'($urandom_range(0, 31));
      step(ev, 5'($urandom_range(0, 31)), $urandom, lsP, la, ld, iv, ia, acc);
      if (acc) lsP = 1'b0;
    end
    for (int i = 0; i < 4; i++) idle_step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
